// File: rtl/dmem_responder.sv
// Single-port word memory answering one request at a time after a fixed latency.
// Requests are sampled only in IDLE; mem_ready strobes for one cycle per response.
module dmem_responder #(
  parameter int DEPTH_WORDS = 1024,
  parameter int LATENCY     = 2
) (
  input  logic        clk,
  input  logic        reset,
  input  logic [31:0] mem_addr,
  input  logic [31:0] mem_write_data,
  input  logic        mem_read,
  input  logic        mem_write,
  output logic [31:0] mem_read_data,
  output logic        mem_ready,
  output logic        busy,
  output logic        err
);

  localparam int AW   = $clog2(DEPTH_WORDS);
  localparam int CW   = (LATENCY > 2) ? $clog2(LATENCY - 1) : 1;
  localparam int LOAD = (LATENCY >= 2) ? (LATENCY - 2) : 0;

  // Handshake: a request is taken on a rising edge when state is IDLE and
  // mem_read or mem_write is high; mem_ready pulses one cycle per request.
  typedef enum logic [1:0] {
    IDLE = 2'd0,
    BUSY = 2'd1,
    RESP = 2'd2
  } state_t;

  state_t          r_state;
  state_t          w_state_next;
  logic [CW-1:0]   r_cnt;
  logic [CW-1:0]   w_cnt_next;
  logic [AW-1:0]   r_idx;
  logic [31:0]     r_wdata;
  logic            r_is_wr;
  logic            r_ready;
  logic [31:0]     r_rdata;
  logic            r_err;
  logic [31:0]     r_mem [DEPTH_WORDS];

  logic            w_accept;
  logic            w_enter_resp;
  logic [AW-1:0]   w_op_idx;
  logic [31:0]     w_op_data;
  logic            w_op_wr;
  logic            w_proto_err;

  assign w_accept    = (r_state == IDLE) && (mem_read || mem_write);
  assign w_proto_err = (mem_read && mem_write) || (mem_addr[1:0] != 2'b00);

  // With LATENCY==1 RESP is entered on the accept edge itself, so the
  // operation must come straight from the ports rather than the latches.
  assign w_op_idx  = w_accept ? mem_addr[AW+1:2] : r_idx;
  assign w_op_data = w_accept ? mem_write_data   : r_wdata;
  assign w_op_wr   = w_accept ? mem_write        : r_is_wr;

  assign w_enter_resp = (r_state != RESP) && (w_state_next == RESP);

  always_comb begin
    w_state_next = r_state;
    w_cnt_next   = r_cnt;
    case (r_state)
      IDLE: begin
        if (w_accept) begin
          if (LATENCY == 1) begin
            w_state_next = RESP;
          end else begin
            w_state_next = BUSY;
            w_cnt_next   = CW'(LOAD);
          end
        end
      end
      BUSY: begin
        if (r_cnt == '0) begin
          w_state_next = RESP;
        end else begin
          w_cnt_next = r_cnt - 1'b1;
        end
      end
      RESP: begin
        w_state_next = IDLE;
      end
      default: begin
        w_state_next = IDLE;
        w_cnt_next   = '0;
      end
    endcase
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_state <= IDLE;
      r_cnt   <= '0;
      r_idx   <= '0;
      r_wdata <= '0;
      r_is_wr <= 1'b0;
      r_ready <= 1'b0;
      r_rdata <= '0;
      r_err   <= 1'b0;
    end else begin
      r_state <= w_state_next;
      r_cnt   <= w_cnt_next;
      r_ready <= (r_state == RESP);
      if (w_accept) begin
        r_idx   <= mem_addr[AW+1:2];
        r_wdata <= mem_write_data;
        r_is_wr <= mem_write;
        if (w_proto_err) begin
          r_err <= 1'b1;
        end
      end
      if (w_enter_resp && !w_op_wr) begin
        r_rdata <= r_mem[w_op_idx];
      end
    end
  end

  // Array has no reset; the reset gate drops a write that has not committed yet.
  always_ff @(posedge clk) begin
    if (w_enter_resp && w_op_wr && !reset) begin
      r_mem[w_op_idx] <= w_op_data;
    end
  end

  assign mem_read_data = r_rdata;
  assign mem_ready     = r_ready;
  assign busy          = (r_state != IDLE);
  assign err           = r_err;

  a_ready_single : assert property (@(posedge clk) disable iff (reset)
    mem_ready |=> !mem_ready);
  a_resp_one_cycle : assert property (@(posedge clk) disable iff (reset)
    (r_state == RESP) |=> (r_state == IDLE));
  a_cnt_range : assert property (@(posedge clk) disable iff (reset)
    (r_state == BUSY) |-> (r_cnt <= CW'(LOAD)));

endmodule

// File: tb/tb_dmem_responder.sv
// Directed bench for dmem_responder: three instances cover LATENCY 2, 3 and 1.
module tb_dmem_responder;

  logic        clk;
  logic        rst   [3];
  logic [31:0] addr  [3];
  logic [31:0] wdata [3];
  logic        rd    [3];
  logic        wr    [3];
  logic [31:0] rdata [3];
  logic        ready [3];
  logic        busy  [3];
  logic        err   [3];

  int lat [3] = '{2, 3, 1};

  int n_checks = 0;
  int n_fail   = 0;
  logic [31:0] exp_q [$];

  dmem_responder #(.DEPTH_WORDS(1024), .LATENCY(2)) u_dut0 (
    .clk(clk), .reset(rst[0]), .mem_addr(addr[0]), .mem_write_data(wdata[0]),
    .mem_read(rd[0]), .mem_write(wr[0]), .mem_read_data(rdata[0]),
    .mem_ready(ready[0]), .busy(busy[0]), .err(err[0])
  );

  dmem_responder #(.DEPTH_WORDS(1024), .LATENCY(3)) u_dut1 (
    .clk(clk), .reset(rst[1]), .mem_addr(addr[1]), .mem_write_data(wdata[1]),
    .mem_read(rd[1]), .mem_write(wr[1]), .mem_read_data(rdata[1]),
    .mem_ready(ready[1]), .busy(busy[1]), .err(err[1])
  );

  dmem_responder #(.DEPTH_WORDS(1024), .LATENCY(1)) u_dut2 (
    .clk(clk), .reset(rst[2]), .mem_addr(addr[2]), .mem_write_data(wdata[2]),
    .mem_read(rd[2]), .mem_write(wr[2]), .mem_read_data(rdata[2]),
    .mem_ready(ready[2]), .busy(busy[2]), .err(err[2])
  );

  // clock / reset
  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: run still active at 200000 time units, required finish");
    $fatal(1);
  end

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%08h expected 0x%08h", tag, got, exp);
    end
  endtask

  task automatic check_reset_outputs(input int d, input string tag);
    check({tag, "_ready"}, 32'(ready[d]), 32'd0);
    check({tag, "_busy"},  32'(busy[d]),  32'd0);
    check({tag, "_err"},   32'(err[d]),   32'd0);
    check({tag, "_rdata"}, rdata[d],      32'd0);
  endtask

  // driver: one request, wait for its response with a cycle budget
  task automatic do_req(input int d, input logic r, input logic w,
                        input logic [31:0] a, input logic [31:0] data, input bit chk_rd);
    int got_lat;
    logic [31:0] exp_v;
    @(negedge clk);
    rd[d] = r; wr[d] = w; addr[d] = a; wdata[d] = data;
    @(posedge clk);
    #1;
    rd[d] = 1'b0; wr[d] = 1'b0;
    check("busy_after_accept", 32'(busy[d]), 32'd1);
    got_lat = 0;
    for (int i = 1; i <= 20; i++) begin
      @(posedge clk);
      #1;
      if (ready[d]) begin
        got_lat = i;
        break;
      end
    end
    check("ready_latency", 32'(got_lat), 32'(lat[d]));
    if (chk_rd) begin
      exp_v = exp_q.pop_front();
      if (got_lat != 0) check("read_data", rdata[d], exp_v);
    end
    @(posedge clk);
    #1;
    check("ready_one_cycle", 32'(ready[d]), 32'd0);
  endtask

  initial begin
    int pulses;
    for (int d = 0; d < 3; d++) begin
      rst[d] = 1'b1; addr[d] = '0; wdata[d] = '0; rd[d] = 1'b0; wr[d] = 1'b0;
    end
    repeat (2) @(negedge clk);
    for (int d = 0; d < 3; d++) check_reset_outputs(d, "por");
    for (int d = 0; d < 3; d++) rst[d] = 1'b0;

    // instance 0, LATENCY 2: basic write/read
    do_req(0, 1'b0, 1'b1, 32'h40, 32'hDEADBEEF, 1'b0);
    exp_q.push_back(32'hDEADBEEF);
    do_req(0, 1'b1, 1'b0, 32'h40, 32'h0, 1'b1);
    check("err_clean", 32'(err[0]), 32'd0);

    // address wrap modulo 4 KiB
    do_req(0, 1'b0, 1'b1, 32'h0, 32'h11111111, 1'b0);
    exp_q.push_back(32'h11111111);
    do_req(0, 1'b1, 1'b0, 32'h1000, 32'h0, 1'b1);

    // request changes while busy are ignored
    do_req(0, 1'b0, 1'b1, 32'h100, 32'h77, 1'b0);
    do_req(0, 1'b0, 1'b1, 32'h200, 32'h88, 1'b0);
    @(negedge clk);
    rd[0] = 1'b1; addr[0] = 32'h100;
    @(posedge clk);
    #1;
    rd[0] = 1'b1; wr[0] = 1'b1; addr[0] = 32'h200; wdata[0] = 32'h99;
    check("ign_busy", 32'(busy[0]), 32'd1);
    pulses = 0;
    for (int i = 1; i <= 6; i++) begin
      @(posedge clk);
      #1;
      if (ready[0]) pulses++;
      if (i == 2) begin
        check("ign_ready_at_2", 32'(ready[0]), 32'd1);
        check("ign_rdata", rdata[0], 32'h77);
        rd[0] = 1'b0; wr[0] = 1'b0;
      end
    end
    check("ign_pulses", 32'(pulses), 32'd1);
    check("ign_err", 32'(err[0]), 32'd0);
    exp_q.push_back(32'h88);
    do_req(0, 1'b1, 1'b0, 32'h200, 32'h0, 1'b1);

    // read+write conflict and misaligned access
    do_req(0, 1'b0, 1'b1, 32'h4, 32'h44444444, 1'b0);
    check("err_before_conflict", 32'(err[0]), 32'd0);
    do_req(0, 1'b1, 1'b1, 32'h8, 32'hA5A5A5A5, 1'b0);
    check("err_conflict", 32'(err[0]), 32'd1);
    exp_q.push_back(32'hA5A5A5A5);
    do_req(0, 1'b1, 1'b0, 32'h8, 32'h0, 1'b1);
    exp_q.push_back(32'h44444444);
    do_req(0, 1'b1, 1'b0, 32'h6, 32'h0, 1'b1);
    check("err_sticky", 32'(err[0]), 32'd1);

    // instance 1, LATENCY 3: reset aborts an uncommitted write
    do_req(1, 1'b0, 1'b1, 32'h20, 32'h12345678, 1'b0);
    exp_q.push_back(32'h12345678);
    do_req(1, 1'b1, 1'b0, 32'h22, 32'h0, 1'b1);
    check("l3_misalign_err", 32'(err[1]), 32'd1);
    @(negedge clk);
    wr[1] = 1'b1; addr[1] = 32'h20; wdata[1] = 32'hCAFEF00D;
    @(posedge clk);
    #1;
    wr[1] = 1'b0;
    @(posedge clk);
    #1;
    check("l3_busy_before_reset", 32'(busy[1]), 32'd1);
    rst[1] = 1'b1;
    #1;
    check_reset_outputs(1, "mid_reset");
    @(posedge clk);
    @(negedge clk);
    rst[1] = 1'b0;
    exp_q.push_back(32'h12345678);
    do_req(1, 1'b1, 1'b0, 32'h20, 32'h0, 1'b1);
    check("l3_err_after_reset", 32'(err[1]), 32'd0);

    // instance 2, LATENCY 1: held read is re-accepted every other cycle
    do_req(2, 1'b0, 1'b1, 32'h10, 32'h0000005A, 1'b0);
    @(negedge clk);
    rd[2] = 1'b1; addr[2] = 32'h10;
    for (int i = 0; i < 6; i++) begin
      @(posedge clk);
      #1;
      check("l1_ready", 32'(ready[2]), 32'(i % 2));
      check("l1_busy",  32'(busy[2]),  32'((i + 1) % 2));
      if (i % 2 == 1) check("l1_rdata", rdata[2], 32'h5A);
    end
    @(negedge clk);
    rd[2] = 1'b0;
    check("l1_err_clean", 32'(err[2]), 32'd0);
    exp_q.push_back(32'h5A);
    do_req(2, 1'b1, 1'b0, 32'h12, 32'h0, 1'b1);
    check("l1_misalign_err", 32'(err[2]), 32'd1);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
